// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// Datapath widths and the opcodes the write-back stage decodes.
package core_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 5;
    localparam int CTRL_W = 5;

    localparam logic [CTRL_W-1:0] OP_LOAD  = 5'b01100;
    localparam logic [CTRL_W-1:0] OP_STORE = 5'b01110;

endpackage

// File: rtl/wb_decode.sv
// Write-back opcode decode.
// Full-width compare of the MA opcode against LOAD and STORE.
module wb_decode
    import core_pkg::*;
(
    input  logic [CTRL_W-1:0] control_ma,
    output logic              is_load,
    output logic              is_store
);

    // Exact match on all opcode bits so no alias can hit either class
    always_comb begin
        is_load  = (control_ma == OP_LOAD);
        is_store = (control_ma == OP_STORE);
    end

endmodule

// File: rtl/register_write_back.sv
// Write-back stage: registers the MA result and drives the RF write port.
// Loads write memory data, stores never write, all else writes the ALU result.
module register_write_back #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int IDX_W  = core_pkg::IDX_W,
    parameter int CTRL_W = core_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  dest_reg_index_ma,
    input  logic              dest_reg_write_en_ma,
    input  logic [DATA_W-1:0] result_ma,
    input  logic [DATA_W-1:0] data_ma,
    input  logic [CTRL_W-1:0] control_ma,
    output logic [IDX_W-1:0]  write_index_rf,
    output logic [DATA_W-1:0] write_data_rf,
    output logic              write_en_rf
);

    logic              is_load;
    logic              is_store;
    logic [IDX_W-1:0]  index_d;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              en_d;
    logic              en_q;

    wb_decode u_decode (
        .control_ma (control_ma),
        .is_load    (is_load),
        .is_store   (is_store)
    );

    // Select write data by opcode and gate the enable off for stores
    always_comb begin
        index_d = dest_reg_index_ma;
        data_d  = is_load ? data_ma : result_ma;
        en_d    = dest_reg_write_en_ma & ~is_store;
    end

    // Output register bank; reset discards any in-flight write at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            index_q <= index_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign write_index_rf = index_q;
    assign write_data_rf  = data_q;
    assign write_en_rf    = en_q;

endmodule

// File: tb/tb_register_write_back.sv
// Scoreboard bench for the write-back stage.
// Driver pushes expected RF writes; a monitor pops and compares each cycle.
module tb_register_write_back;

    localparam logic [4:0] LD = 5'b01100;
    localparam logic [4:0] ST = 5'b01110;

    typedef struct packed {
        logic [4:0]  idx;
        logic        en;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  dest_reg_index_ma;
    logic        dest_reg_write_en_ma;
    logic [15:0] result_ma;
    logic [15:0] data_ma;
    logic [4:0]  control_ma;
    logic [4:0]  write_index_rf;
    logic [15:0] write_data_rf;
    logic        write_en_rf;

    exp_t q[$];
    bit   mon_en;
    int   checks;
    int   errors;

    register_write_back dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dest_reg_index_ma    (dest_reg_index_ma),
        .dest_reg_write_en_ma (dest_reg_write_en_ma),
        .result_ma            (result_ma),
        .data_ma              (data_ma),
        .control_ma           (control_ma),
        .write_index_rf       (write_index_rf),
        .write_data_rf        (write_data_rf),
        .write_en_rf          (write_en_rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a write happens unless disabled or a store;
    // loads deliver memory data, everything else the ALU result.
    function automatic exp_t model(input logic [4:0] idx, input logic en,
                                   input logic [15:0] res,
                                   input logic [15:0] dat,
                                   input logic [4:0] op);
        exp_t e;
        e.idx  = idx;
        e.en   = en && (op != ST);
        e.data = (op == LD) ? dat : res;
        return e;
    endfunction

    task automatic drive(input logic [4:0] idx, input logic en,
                         input logic [15:0] res, input logic [15:0] dat,
                         input logic [4:0] op);
        @(negedge clk);
        dest_reg_index_ma    = idx;
        dest_reg_write_en_ma = en;
        result_ma            = res;
        data_ma              = dat;
        control_ma           = op;
        q.push_back(model(idx, en, res, dat, op));
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (write_en_rf !== 1'b0 || write_index_rf !== 5'd0 ||
            write_data_rf !== 16'd0) begin
            errors++;
            $display("FAIL %s: got en=%b idx=%0d data=%h, want all zero",
                     tag, write_en_rf, write_index_rf, write_data_rf);
        end
    endtask

    // Monitor: one RF write per cycle, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (write_en_rf !== e.en || write_index_rf !== e.idx ||
                    (e.en && write_data_rf !== e.data)) begin
                    errors++;
                    $display("FAIL wb_write: got en=%b idx=%0d data=%h, want en=%b idx=%0d data=%h",
                             write_en_rf, write_index_rf, write_data_rf,
                             e.en, e.idx, e.data);
                end
            end
        end
    end

    initial begin
        logic [4:0] op;
        int         wait_cyc;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;

        // Reset held with an active LOAD on the inputs
        rst_n                = 1'b0;
        dest_reg_index_ma    = 5'd7;
        dest_reg_write_en_ma = 1'b1;
        result_ma            = 16'h1234;
        data_ma              = 16'h5678;
        control_ma           = LD;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        drive(5'd3, 1'b1, 16'd10, 16'd11, LD);
        drive(5'd3, 1'b1, 16'd10, 16'd11, ST);
        drive(5'd31, 1'b1, 16'hBEEF, 16'h0000, 5'b00001);
        drive(5'd3, 1'b0, 16'd10, 16'd11, LD);
        drive(5'd0, 1'b1, 16'h00AA, 16'h0055, 5'b00000);
        for (int i = 0; i < 8; i++)
            drive(5'd4, 1'b1, 16'd10, 16'd11, (i % 2 == 0) ? LD : ST);

        // Mid-stream reset between edges after a write is presented
        drive(5'd9, 1'b1, 16'd1, 16'hCAFE, LD);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("reset_async");
        q.delete();
        @(negedge clk);
        check_zero("reset_mid_hold");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Randomised traffic, biased toward the memory opcodes
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(3))
                0: op = LD;
                1: op = ST;
                default: op = 5'($urandom);
            endcase
            drive(5'($urandom), 1'($urandom), 16'($urandom),
                  16'($urandom), op);
        end

        // Drain the scoreboard with a bounded wait
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d writes left, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
